// File: rtl/convolution_3x3.sv
// convolution_3x3
//   3x3 spatial convolution on an RGB565 stream fed one column per beat by a
//   three-row line buffer. A signed 8-bit kernel is applied to R, G and B
//   independently; each channel sum is arithmetically shifted and clamped.
//   Fixed latency: a beat sampled at edge N is on the outputs after edge N+4.
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   data_in         column of three RGB565 pixels, [0] = top row, [2] = bottom
//   hcount_in       column index of data_in
//   vcount_in       row index of the window centre
//   data_valid_in   beat qualifier
//   line_out        filtered RGB565 pixel
//   hcount_out      column of the filtered pixel (hcount_in - 1)
//   vcount_out      row of the filtered pixel
//   data_valid_out  one-cycle strobe per produced pixel
module convolution_3x3 #(
    parameter int          HRES   = 1280,
    parameter int          VRES   = 720,
    parameter logic [71:0] KERNEL = 72'h01_02_01_02_04_02_01_02_01,
    parameter int          SHIFT  = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [2:0][15:0] data_in,
    input  logic [10:0]      hcount_in,
    input  logic [9:0]       vcount_in,
    input  logic             data_valid_in,
    output logic [15:0]      line_out,
    output logic [10:0]      hcount_out,
    output logic [9:0]       vcount_out,
    output logic             data_valid_out
);

    localparam int STAGES = 4;

    // hcount/vcount port widths bound the supported frame size
    if (HRES < 3 || HRES > 2048 || VRES < 1 || VRES > 1024) begin : g_bad_res
        $error("convolution_3x3: HRES/VRES out of range for port widths");
    end

    // ------------------------------------------------------------------
    // helpers
    // ------------------------------------------------------------------
    // k[r][c], sign-extended; MSB byte of KERNEL is the top-left tap
    function automatic logic signed [15:0] coef(input int r, input int c);
        logic [7:0] k;
        k = KERNEL[71-8*(3*r+c) -: 8];
        return {{8{k[7]}}, k};
    endfunction

    // channel 0 = R, 1 = G, 2 = B, zero-extended so it multiplies as positive
    function automatic logic signed [15:0] chan(input logic [15:0] p, input int ch);
        case (ch)
            0:       return {11'd0, p[15:11]};
            1:       return {10'd0, p[10:5]};
            default: return {11'd0, p[4:0]};
        endcase
    endfunction

    function automatic logic signed [19:0] ext20(input logic signed [15:0] x);
        return {{4{x[15]}}, x};
    endfunction

    function automatic logic [5:0] clamp(input logic signed [19:0] s, input logic [5:0] maxv);
        logic signed [19:0] t;
        t = s >>> SHIFT;
        if (t < 0)
            return 6'd0;
        if (t > $signed({14'd0, maxv}))
            return maxv;
        return t[5:0];
    endfunction

    // ------------------------------------------------------------------
    // S1: window and metadata capture
    // ------------------------------------------------------------------
    logic [15:0] win [3][3];

    // hcount 0 has no complete left neighbour pair for a new centre, so it
    // shifts the window but never produces a pixel
    logic beat_ok;
    assign beat_ok = data_valid_in && (hcount_in != 11'd0);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else if (data_valid_in) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
                win[r][2] <= data_in[r];
            end
        end
    end

    // metadata pipe runs beside the datapath; index i is valid after stage i
    logic [STAGES:1] vld_pipe;
    logic [10:0]     h_pipe [1:STAGES];
    logic [9:0]      v_pipe [1:STAGES];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_pipe <= '0;
            for (int i = 1; i <= STAGES; i++) begin
                h_pipe[i] <= '0;
                v_pipe[i] <= '0;
            end
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], beat_ok};
            if (beat_ok) begin
                h_pipe[1] <= hcount_in - 11'd1;
                v_pipe[1] <= vcount_in;
            end
            for (int i = 2; i <= STAGES; i++) begin
                if (vld_pipe[i-1]) begin
                    h_pipe[i] <= h_pipe[i-1];
                    v_pipe[i] <= v_pipe[i-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: 27 products, indexed [channel][row][col]
    // ------------------------------------------------------------------
    logic signed [15:0] prod_c [3][3][3];
    logic signed [15:0] prod_q [3][3][3];

    always_comb begin
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    prod_c[ch][r][c] = coef(r, c) * chan(win[r][c], ch);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int ch = 0; ch < 3; ch++)
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        prod_q[ch][r][c] <= '0;
        end else if (vld_pipe[1]) begin
            prod_q <= prod_c;
        end
    end

    // ------------------------------------------------------------------
    // S3: 9-term sums, split into row sums then the channel total so that
    // each register stage sees at most a 3-input adder
    // ------------------------------------------------------------------
    logic signed [19:0] rsum_c [3][3];
    logic signed [19:0] rsum_q [3][3];
    logic signed [19:0] sum_c  [3];
    logic signed [19:0] sum_q  [3];

    always_comb begin
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 3; r++)
                rsum_c[ch][r] = ext20(prod_q[ch][r][0]) + ext20(prod_q[ch][r][1])
                              + ext20(prod_q[ch][r][2]);
        for (int ch = 0; ch < 3; ch++)
            sum_c[ch] = rsum_q[ch][0] + rsum_q[ch][1] + rsum_q[ch][2];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int ch = 0; ch < 3; ch++) begin
                sum_q[ch] <= '0;
                for (int r = 0; r < 3; r++)
                    rsum_q[ch][r] <= '0;
            end
        end else begin
            if (vld_pipe[2])
                rsum_q <= rsum_c;
            if (vld_pipe[3])
                sum_q <= sum_c;
        end
    end

    // ------------------------------------------------------------------
    // S4: shift, clamp, pack; outputs hold between valid results
    // ------------------------------------------------------------------
    logic [15:0] pixel_c;

    always_comb begin
        pixel_c = {5'(clamp(sum_q[0], 6'd31)),
                   clamp(sum_q[1], 6'd63),
                   5'(clamp(sum_q[2], 6'd31))};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            line_out       <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= vld_pipe[STAGES];
            if (vld_pipe[STAGES]) begin
                line_out   <= pixel_c;
                hcount_out <= h_pipe[STAGES];
                vcount_out <= v_pipe[STAGES];
            end
        end
    end

endmodule

// File: tb/tb_convolution_3x3.sv
// Bench for convolution_3x3: two instances (default Gaussian, and sharpen
// with SHIFT = 0) share one input stream. A reference window model computes
// each expected pixel when a beat is driven and queues it with its due cycle;
// a monitor on the falling edge pops and compares pixel, counts and timing.
module tb_convolution_3x3;

    localparam logic [71:0] KA = 72'h01_02_01_02_04_02_01_02_01;
    localparam logic [71:0] KB = 72'h00_FF_00_FF_05_FF_00_FF_00;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0][15:0] din;
    logic [10:0]      hin;
    logic [9:0]       vin;
    logic             vld;
    logic [15:0]      lo_a, lo_b;
    logic [10:0]      ho_a, ho_b;
    logic [9:0]       vo_a, vo_b;
    logic             dvo_a, dvo_b;

    always #5 clk = ~clk;

    convolution_3x3 dut_a (
        .clk_in(clk), .rst_in(rst), .data_in(din), .hcount_in(hin),
        .vcount_in(vin), .data_valid_in(vld), .line_out(lo_a),
        .hcount_out(ho_a), .vcount_out(vo_a), .data_valid_out(dvo_a)
    );

    convolution_3x3 #(.KERNEL(KB), .SHIFT(0)) dut_b (
        .clk_in(clk), .rst_in(rst), .data_in(din), .hcount_in(hin),
        .vcount_in(vin), .data_valid_in(vld), .line_out(lo_b),
        .hcount_out(ho_b), .vcount_out(vo_b), .data_valid_out(dvo_b)
    );

    typedef struct {
        logic [15:0] pa;
        logic [15:0] pb;
        logic [10:0] h;
        logic [9:0]  v;
        int          due;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [15:0] mw [3][3];
    logic [15:0] seen_a [0:2047];
    logic [15:0] seen_b [0:2047];
    int          hlog[$];

    always @(posedge clk) cyc <= cyc + 1;

    // reference: plain integer convolution of the model window
    function automatic logic [15:0] conv(input logic [71:0] k, input int sh);
        logic [15:0] o;
        int sum, coef, v, res, mx;
        o = '0;
        for (int ch = 0; ch < 3; ch++) begin
            sum = 0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    coef = $signed(k[71-8*(3*r+c) -: 8]);
                    if (ch == 0)      v = int'(mw[r][c][15:11]);
                    else if (ch == 1) v = int'(mw[r][c][10:5]);
                    else              v = int'(mw[r][c][4:0]);
                    sum += coef * v;
                end
            res = sum >>> sh;
            mx  = (ch == 1) ? 63 : 31;
            if (res < 0)  res = 0;
            if (res > mx) res = mx;
            if (ch == 0)      o[15:11] = res[4:0];
            else if (ch == 1) o[10:5]  = res[5:0];
            else              o[4:0]   = res[4:0];
        end
        return o;
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (dvo_a || dvo_b) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL spurious_valid cyc=%0d a=%h h=%0d expected no output", cyc, lo_a, ho_a);
            end else begin
                mon_e = q.pop_front();
                if ({dvo_a, dvo_b, lo_a, lo_b, ho_a, ho_b, vo_a, vo_b} !==
                    {2'b11, mon_e.pa, mon_e.pb, mon_e.h, mon_e.h, mon_e.v, mon_e.v} || cyc != mon_e.due) begin
                    bad++;
                    $display("FAIL output got vld=%b%b a=%h b=%h h=%0d/%0d v=%0d/%0d cyc=%0d expected a=%h b=%h h=%0d v=%0d cyc=%0d",
                             dvo_a, dvo_b, lo_a, lo_b, ho_a, ho_b, vo_a, vo_b, cyc,
                             mon_e.pa, mon_e.pb, mon_e.h, mon_e.v, mon_e.due);
                end
                seen_a[ho_a] = lo_a;
                seen_b[ho_b] = lo_b;
                hlog.push_back(int'(ho_a));
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            total++;
            bad++;
            $display("FAIL missing_output cyc=%0d expected h=%0d a=%h at cyc=%0d", cyc, q[0].h, q[0].pa, q[0].due);
            void'(q.pop_front());
        end
    end

    task automatic beat(input logic [15:0] t, input logic [15:0] m, input logic [15:0] b,
                        input logic [10:0] h, input logic [9:0] v);
        @(negedge clk);
        din[0] = t; din[1] = m; din[2] = b;
        hin = h; vin = v; vld = 1'b1;
        for (int r = 0; r < 3; r++) begin
            mw[r][0] = mw[r][1];
            mw[r][1] = mw[r][2];
        end
        mw[0][2] = t; mw[1][2] = m; mw[2][2] = b;
        if (h != 11'd0)
            q.push_back('{conv(KA, 4), conv(KB, 0), h - 11'd1, v, cyc + 5});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vld = 1'b0;
            din[0] = 16'($urandom); din[1] = 16'($urandom); din[2] = 16'($urandom);
            hin = 11'($urandom); vin = 10'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 40) begin
            idle(1);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending=%0d expected 0", q.size());
            q.delete();
        end
        idle(2);
    endtask

    // reset for one edge; optionally with a simultaneous beat that must be dropped
    task automatic do_reset(input logic with_beat);
        @(negedge clk);
        rst = 1'b1;
        vld = with_beat;
        din[0] = 16'hFFFF; din[1] = 16'hFFFF; din[2] = 16'hFFFF;
        hin = 11'd13; vin = 10'd50;
        while (q.size() > 0 && q[q.size()-1].due > cyc)
            void'(q.pop_back());
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                mw[r][c] = '0;
        @(negedge clk);
        rst = 1'b0;
        vld = 1'b0;
        total++;
        if ({lo_a, ho_a, vo_a, dvo_a, lo_b, ho_b, vo_b, dvo_b} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got a=%h h=%0d v=%0d vld=%b b=%h h=%0d v=%0d vld=%b expected all 0",
                     lo_a, ho_a, vo_a, dvo_a, lo_b, ho_b, vo_b, dvo_b);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
    endtask

    task automatic test_uniform();
        for (int h = 0; h < 20; h++)
            beat(16'h8410, 16'h8410, 16'h8410, 11'(h), 10'd10);
        drain();
        total++;
        if (lo_a !== 16'h8410) begin
            bad++;
            $display("FAIL uniform_value got %h expected 8410", lo_a);
        end
    endtask

    task automatic test_impulse(input int gap);
        for (int h = 4; h <= 7; h++) seen_a[h] = 'x;
        for (int h = 0; h < 10; h++) begin
            beat(16'h0000, (h == 5) ? 16'hFFFF : 16'h0000, 16'h0000, 11'(h), 10'd30);
            idle(gap);
        end
        drain();
        total++;
        if ({seen_a[4], seen_a[5], seen_a[6], seen_a[7]} !== {16'h18E3, 16'h39E7, 16'h18E3, 16'h0000}) begin
            bad++;
            $display("FAIL impulse gap=%0d got %h %h %h %h expected 18e3 39e7 18e3 0000",
                     gap, seen_a[4], seen_a[5], seen_a[6], seen_a[7]);
        end
    endtask

    task automatic test_clamp();
        logic [15:0] top [8];
        logic [15:0] mid [8];
        top = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        mid = '{16'h0, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 16'hFFFF};
        seen_b[2] = 'x;
        seen_b[5] = 'x;
        for (int h = 0; h < 8; h++)
            beat(top[h], mid[h], top[h], 11'(h), 10'd60);
        drain();
        total++;
        if (seen_b[2] !== 16'hFFFF) begin
            bad++;
            $display("FAIL clamp_pos got %h expected ffff", seen_b[2]);
        end
        total++;
        if (seen_b[5] !== 16'h0000) begin
            bad++;
            $display("FAIL clamp_neg got %h expected 0000", seen_b[5]);
        end
    endtask

    task automatic test_line_boundary();
        int exp_h [6];
        exp_h = '{1275, 1276, 1277, 1278, 0, 1};
        hlog.delete();
        for (int h = 1276; h <= 1279; h++)
            beat(16'h1234, 16'h5678, 16'h9ABC, 11'(h), 10'd40);
        for (int h = 0; h <= 2; h++)
            beat(16'hFEDC, 16'hBA98, 16'h7654, 11'(h), 10'd41);
        drain();
        total++;
        if (hlog.size() != 6) begin
            bad++;
            $display("FAIL line_count got %0d expected 6", hlog.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (hlog[i] != exp_h[i]) begin
                    bad++;
                    $display("FAIL line_hcount[%0d] got %0d expected %0d", i, hlog[i], exp_h[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int h = 10; h <= 12; h++)
            beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 11'(h), 10'd50);
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            total++;
            if (dvo_a !== 1'b0 || dvo_b !== 1'b0 || lo_a !== 16'h0) begin
                bad++;
                $display("FAIL reset_flush[%0d] got vld=%b%b a=%h expected 0", i, dvo_a, dvo_b, lo_a);
            end
        end
        seen_a[0] = 'x;
        beat(16'h0000, 16'hFFFF, 16'h0000, 11'd1, 10'd51);
        beat(16'h0000, 16'h0000, 16'h0000, 11'd2, 10'd51);
        drain();
        total++;
        if (seen_a[0] !== 16'h18E3) begin
            bad++;
            $display("FAIL post_reset_edge got %h expected 18e3", seen_a[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        vld = 1'b0;
        din = '0;
        hin = '0;
        vin = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                mw[r][c] = '0;
        test_reset();
        test_uniform();
        test_impulse(0);
        test_impulse(2);
        test_clamp();
        test_line_boundary();
        test_reset_mid();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got %0d expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
